paridad_word_tx: RTL and testbench

- Serial word transmitter and parity generator for the iterative parity-cell chain. It is the sending end of that chain.
- Accepts a parallel N-bit word through a valid/ready handshake.
- Emits the word MSB-first as the serial bit stream L, one bit per accepted beat.
- After the data bits it appends one parity bit, so that a downstream checker sees the frame parity selected by PAR_ODD.

---
 rtl/paridad_pkg.sv | 21 ++
 rtl/paridad_acc.sv | 26 ++
 rtl/paridad_word_tx.sv | 124 ++++++++++++
 tb/tb_paridad_word_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/paridad_pkg.sv
// rtl/paridad_pkg.sv - shared encodings and widths for the parity word transmitter
package paridad_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam int FRAME_CW = 8;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SHIFT  = ST_SHIFT,
        S_PARITY = ST_PARITY
    } state_t;

    // Bit-counter width for an N-bit word; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/paridad_acc.sv
// rtl/paridad_acc.sv - toggle-cell parity accumulator
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : fold bit_in into the accumulator this cycle
//   bit_in     : bit to accumulate
//   p          : running XOR of every accumulated bit since the last clear
module paridad_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic p
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= 1'b0;
        end else if (clr) begin
            p <= 1'b0;
        end else if (en) begin
            p <= p ^ bit_in;
        end
    end

endmodule

// File: rtl/paridad_word_tx.sv
// rtl/paridad_word_tx.sv - serial MSB-first word transmitter with appended parity bit
//   clk, rst_n          : clock, asynchronous active-low reset
//   din/din_valid       : parallel word in; taken only while din_ready (IDLE)
//   din_ready           : block is idle and can load a word
//   L/L_valid/L_ready   : serial frame bit stream with sink back-pressure
//   L_last              : current L is the parity bit
//   busy                : frame in progress (SHIFT or PARITY)
//   frame_cnt           : completed frames, wraps modulo 256
module paridad_word_tx
    import paridad_pkg::*;
#(
    parameter int N       = 8,
    parameter bit PAR_ODD = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic                L,
    output logic                L_valid,
    input  logic                L_ready,
    output logic                L_last,
    output logic                busy,
    output logic [FRAME_CW-1:0] frame_cnt
);

    localparam int CW = cnt_width(N);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic            p;
    logic            load;
    logic            shift_beat;
    logic            parity_beat;

    // Outputs are decoded from registered state only, so an asynchronous
    // reset drives them to their idle values without waiting for a clock.
    always_comb begin
        state_nxt   = state;
        din_ready   = 1'b0;
        L           = 1'b0;
        L_valid     = 1'b0;
        L_last      = 1'b0;
        busy        = 1'b0;
        load        = 1'b0;
        shift_beat  = 1'b0;
        parity_beat = 1'b0;
        case (state)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                L          = shreg[N-1];
                L_valid    = 1'b1;
                busy       = 1'b1;
                shift_beat = L_ready;
                if (L_ready && (cnt == '0)) begin
                    state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                L           = p ^ PAR_ODD;
                L_valid     = 1'b1;
                L_last      = 1'b1;
                busy        = 1'b1;
                parity_beat = L_ready;
                if (L_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= din;
            cnt   <= CW'(N - 1);
        end else if (shift_beat) begin
            shreg <= {shreg[N-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (parity_beat) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Parity is folded in from the bits actually sent, not recomputed from
    // din, because din is free to change once the word has been loaded.
    paridad_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (load),
        .en     (shift_beat),
        .bit_in (shreg[N-1]),
        .p      (p)
    );

endmodule

// File: tb/tb_paridad_word_tx.sv
// tb/tb_paridad_word_tx.sv - directed self-checking bench for paridad_word_tx
module tb_paridad_word_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       L_ready;

    logic       l_o, lv_o, ll_o, busy_o, dr_o;
    logic [7:0] fc_o;
    logic       l_e, lv_e, ll_e, busy_e, dr_e;
    logic [7:0] fc_e;

    int         n_cmp;
    int         n_err;
    logic [7:0] exp_cnt;

    paridad_word_tx #(.N(8), .PAR_ODD(1'b1)) u_odd (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (dr_o),
        .L         (l_o),
        .L_valid   (lv_o),
        .L_ready   (L_ready),
        .L_last    (ll_o),
        .busy      (busy_o),
        .frame_cnt (fc_o)
    );

    paridad_word_tx #(.N(8), .PAR_ODD(1'b0)) u_even (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (dr_e),
        .L         (l_e),
        .L_valid   (lv_e),
        .L_ready   (L_ready),
        .L_last    (ll_e),
        .busy      (busy_e),
        .frame_cnt (fc_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with both DUTs idle. Sends word w and checks every
    // beat against the MSB-first data followed by the expected parity bits.
    task automatic run_frame(input logic [7:0] w, input bit stall, input bit hold);
        int   idx;
        int   cyc;
        bit   stalled;
        logic pl_o, pl_e;
        logic exp_o, exp_e;
        idx     = 0;
        cyc     = 0;
        stalled = 1'b0;
        pl_o    = 1'b0;
        pl_e    = 1'b0;
        chk("din_ready_idle", dr_o, 1);
        din       = w;
        din_valid = 1'b1;
        L_ready   = 1'b1;
        @(negedge clk);
        if (!hold) din_valid = 1'b0;
        while (idx < 9 && cyc < 300) begin
            if (hold) din = 8'($urandom);
            chk("l_valid", {31'd0, lv_o & lv_e}, 1);
            chk("din_ready_busy", {31'd0, dr_o | dr_e}, 0);
            chk("busy", {31'd0, busy_o & busy_e}, 1);
            if (stalled) begin
                chk("stall_hold_odd", l_o, pl_o);
                chk("stall_hold_even", l_e, pl_e);
            end
            L_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (L_ready) begin
                if (idx < 8) begin
                    exp_o = w[7 - idx];
                    exp_e = w[7 - idx];
                end else begin
                    exp_o = ~^w;
                    exp_e = ^w;
                end
                chk("bit_odd", l_o, exp_o);
                chk("bit_even", l_e, exp_e);
                chk("last_odd", ll_o, (idx == 8));
                chk("last_even", ll_e, (idx == 8));
                idx++;
            end
            stalled = !L_ready;
            pl_o    = l_o;
            pl_e    = l_e;
            @(negedge clk);
            cyc++;
        end
        if (idx < 9) chk("frame_timeout", idx, 9);
        if (!stall) chk("frame_cycles", cyc, 9);
        L_ready = 1'b1;
        exp_cnt++;
        chk("frame_cnt_odd", fc_o, exp_cnt);
        chk("frame_cnt_even", fc_e, exp_cnt);
        chk("idle_l_valid", {31'd0, lv_o | lv_e}, 0);
        chk("idle_busy", {31'd0, busy_o | busy_e}, 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_cnt   = 8'd0;
        rst_n     = 1'b0;
        din       = 8'd0;
        din_valid = 1'b0;
        L_ready   = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_l", {31'd0, l_o | l_e}, 0);
        chk("rst_l_valid", {31'd0, lv_o | lv_e}, 0);
        chk("rst_l_last", {31'd0, ll_o | ll_e}, 0);
        chk("rst_busy", {31'd0, busy_o | busy_e}, 0);
        chk("rst_din_ready", {31'd0, dr_o & dr_e}, 1);
        chk("rst_frame_cnt", fc_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, then all-ones and all-zero words.
        run_frame(8'b1011_0010, 1'b0, 1'b0);
        run_frame(8'hFF, 1'b0, 1'b0);
        run_frame(8'h00, 1'b0, 1'b0);

        // Back-pressure in idle is harmless; random stalls inside a frame.
        L_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_stall_l_valid", lv_o, 0);
        chk("idle_stall_din_ready", dr_o, 1);
        L_ready = 1'b1;
        run_frame(8'hA5, 1'b1, 1'b0);
        run_frame(8'h4E, 1'b1, 1'b0);

        // din_valid held with din churning: only idle-cycle words are sent,
        // back-to-back loads every N+2 cycles.
        run_frame(8'h3C, 1'b0, 1'b1);
        run_frame(8'h96, 1'b0, 1'b1);
        din_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset after the 4th beat of a frame.
        din       = 8'hC3;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_frame_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_l", {31'd0, l_o | l_e}, 0);
        chk("async_l_valid", {31'd0, lv_o | lv_e}, 0);
        chk("async_l_last", {31'd0, ll_o | ll_e}, 0);
        chk("async_busy", {31'd0, busy_o | busy_e}, 0);
        chk("async_din_ready", {31'd0, dr_o & dr_e}, 1);
        chk("async_frame_cnt", fc_o, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
        @(negedge clk);
        run_frame(8'h5A, 1'b0, 1'b0);

        // Frame counter wrap 255 -> 0.
        while (exp_cnt != 8'd255) run_frame(8'($urandom), 1'b0, 1'b0);
        chk("cnt_before_wrap", fc_o, 255);
        run_frame(8'h81, 1'b0, 1'b0);
        chk("cnt_wrap_odd", fc_o, 0);
        chk("cnt_wrap_even", fc_e, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
